// File: rtl/ahb_timer_irqc.sv
// Interrupt controller/arbiter for the four AHB timer compare channels: edge-to-pending, arbitration, claim/EOI handshake.
// Define IRQC_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module ahb_timer_irqc #(
    parameter int LOST_W = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [4:2]  HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic [3:0]  match,
    output logic        irq,
    output logic [1:0]  irq_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] A_EN    = 3'd0;
    localparam logic [2:0] A_PEND  = 3'd1;
    localparam logic [2:0] A_CLAIM = 3'd2;
    localparam logic [2:0] A_EOI   = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;
    localparam logic [2:0] A_LOST  = 3'd5;

    state_t              state;
    logic [3:0]          en;
    logic [3:0]          pend;
    logic [3:0]          match_q;
    logic [1:0]          active_id;
    logic [LOST_W-1:0]   lost [4];

    logic                wr;
    logic                wr_en;
    logic                wr_pend;
    logic                wr_claim;
    logic                wr_eoi;
    logic                wr_lost;
    logic [3:0]          rise;
    logic [3:0]          cand;
    logic                valid;
    logic [1:0]          winner;
    logic [1:0]          arb_start;
    logic [1:0]          idx;
    logic                found;
    logic                claim_ok;
    logic [3:0]          claim_clr;
    logic [3:0]          w1c;
    logic                unused_ok;

    assign wr       = HSEL & HWRITE;
    assign wr_en    = wr && (HADDR == A_EN);
    assign wr_pend  = wr && (HADDR == A_PEND);
    assign wr_claim = wr && (HADDR == A_CLAIM);
    assign wr_eoi   = wr && (HADDR == A_EOI);
    assign wr_lost  = wr && (HADDR == A_LOST);

    assign rise      = match & ~match_q;
    assign cand      = pend & en;
    assign valid     = |cand;
    assign claim_ok  = wr_claim && (state == OFFER) && valid;
    assign claim_clr = claim_ok ? (4'b0001 << winner) : 4'b0000;
    assign w1c       = wr_pend ? HWDATA[3:0] : 4'b0000;
    assign unused_ok = ^HWDATA[31:4];

`ifdef IRQC_RR_EN
    logic [1:0] rr_ptr;

    // Pointer holds the id just after the last claimed channel.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr <= 2'd0;
        end else if (claim_ok) begin
            rr_ptr <= winner + 2'd1;
        end
    end

    assign arb_start = rr_ptr;
`else
    assign arb_start = 2'd0;
`endif

    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = arb_start + 2'(k);
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Edge set is ORed in last so it beats both W1C and claim clears.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en      <= 4'b0000;
            pend    <= 4'b0000;
            match_q <= 4'b0000;
        end else begin
            match_q <= match;
            if (wr_en) begin
                en <= HWDATA[3:0];
            end
            pend <= (pend & ~(w1c | claim_clr)) | rise;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 4; i++) begin
                lost[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lost) begin
                    lost[i] <= '0;
                end else if (rise[i] && pend[i] && !claim_clr[i] && (lost[i] != '1)) begin
                    lost[i] <= lost[i] + LOST_W'(1);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            irq       <= 1'b0;
            irq_id    <= 2'd0;
            active_id <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        state  <= OFFER;
                        irq    <= 1'b1;
                        irq_id <= winner;
                    end
                end
                OFFER: begin
                    if (!valid) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end else if (wr_claim) begin
                        state     <= ACTIVE;
                        irq       <= 1'b0;
                        active_id <= winner;
                        irq_id    <= winner;
                    end else begin
                        irq_id <= winner;
                    end
                end
                ACTIVE: begin
                    if (wr_eoi && (HWDATA[1:0] == active_id)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        case (HADDR)
            A_EN:    HRDATA[3:0] = en;
            A_PEND:  HRDATA[3:0] = pend;
            A_CLAIM: begin
                HRDATA[31]  = valid;
                HRDATA[1:0] = winner;
            end
            A_STAT: begin
                HRDATA[9:8] = state;
                HRDATA[5:4] = active_id;
            end
            A_LOST: begin
                for (int i = 0; i < 4; i++) begin
                    HRDATA[8*i +: LOST_W] = lost[i];
                end
            end
            default: HRDATA = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ahb_timer_irqc.sv
// Directed self-checking bench for ahb_timer_irqc; expected values hand-derived from the register map and handshake rules.
module tb_ahb_timer_irqc;

    localparam logic [2:0] A_EN    = 3'd0;
    localparam logic [2:0] A_PEND  = 3'd1;
    localparam logic [2:0] A_CLAIM = 3'd2;
    localparam logic [2:0] A_EOI   = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;
    localparam logic [2:0] A_LOST  = 3'd5;

`ifdef IRQC_RR_EN
    localparam logic [1:0] FIRST_ID  = 2'd2;
    localparam logic [1:0] SECOND_ID = 2'd1;
`else
    localparam logic [1:0] FIRST_ID  = 2'd1;
    localparam logic [1:0] SECOND_ID = 2'd2;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [4:2]  HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [3:0]  match;
    logic        irq;
    logic [1:0]  irq_id;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    ahb_timer_irqc #(.LOST_W(8)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .HSEL   (HSEL),
        .HADDR  (HADDR),
        .HWRITE (HWRITE),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .match  (match),
        .irq    (irq),
        .irq_id (irq_id)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HADDR  = a;
        HWDATA = d;
        tick();
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HWDATA = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        HSEL   = 1'b1;
        HWRITE = 1'b0;
        HADDR  = a;
        #1;
        d      = HRDATA;
        HSEL   = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HWRITE  = 1'b0;
        HADDR   = 3'd0;
        HWDATA  = 32'd0;
        match   = 4'd0;
        #12;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        checks++;
        if (irq_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_irq_id: got %0d expected 0", irq_id); end
        bus_read(A_EN, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_en: got %h expected 00000000", rd); end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_stat: got %h expected 00000000", rd); end
        bus_read(A_LOST, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_lost: got %h expected 00000000", rd); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus_write(A_EN, 32'h1);
        match = 4'b0001;
        tick();
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("[TB] FAIL single_pend_n1: got %h expected 00000001", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL single_irq_n1: got %b expected 0", irq); end
        tick();
        match = 4'b0000;
        checks++;
        if (irq !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("[TB] FAIL single_irq_n2: got irq=%b id=%0d expected irq=1 id=0", irq, irq_id);
        end
        bus_read(A_CLAIM, rd);
        checks++;
        if (rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL single_claim_read: got %h expected 80000000", rd); end
        bus_write(A_CLAIM, 32'h0);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h200) begin errors++; $display("[TB] FAIL single_stat_active: got %h expected 00000200", rd); end
        bus_write(A_EOI, 32'h0);
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL single_pend_after: got %h expected 00000000", rd); end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL single_stat_idle: got %h expected 00000000", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL single_irq_after: got %b expected 0", irq); end
    endtask

    task automatic test_simultaneous();
        bus_write(A_EN, 32'hF);
`ifdef IRQC_RR_EN
        match = 4'b0010;
        tick();
        match = 4'b0000;
        tick();
        tick();
        bus_write(A_CLAIM, 32'h0);
        bus_write(A_EOI, 32'h1);
`endif
        match = 4'b0110;
        tick();
        match = 4'b0000;
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== FIRST_ID) begin
            errors++; $display("[TB] FAIL simul_first_offer: got irq=%b id=%0d expected irq=1 id=%0d", irq, irq_id, FIRST_ID);
        end
        bus_read(A_CLAIM, rd);
        checks++;
        if (rd !== (32'h8000_0000 | 32'(FIRST_ID))) begin
            errors++; $display("[TB] FAIL simul_claim_read: got %h expected %h", rd, 32'h8000_0000 | 32'(FIRST_ID));
        end
        bus_write(A_CLAIM, 32'h0);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== (32'h200 | (32'(FIRST_ID) << 4))) begin
            errors++; $display("[TB] FAIL simul_stat_first: got %h expected %h", rd, 32'h200 | (32'(FIRST_ID) << 4));
        end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== (32'h6 & ~(32'h1 << FIRST_ID))) begin
            errors++; $display("[TB] FAIL simul_pend_after_claim: got %h expected %h", rd, 32'h6 & ~(32'h1 << FIRST_ID));
        end
        bus_write(A_EOI, 32'(FIRST_ID));
        checks++;
        if (irq !== 1'b0 || irq_id !== FIRST_ID) begin
            errors++; $display("[TB] FAIL simul_dead_cycle: got irq=%b id=%0d expected irq=0 id=%0d", irq, irq_id, FIRST_ID);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== SECOND_ID) begin
            errors++; $display("[TB] FAIL simul_second_offer: got irq=%b id=%0d expected irq=1 id=%0d", irq, irq_id, SECOND_ID);
        end
        bus_write(A_CLAIM, 32'h0);
        bus_write(A_EOI, 32'(SECOND_ID));
        tick();
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== (32'(SECOND_ID) << 4)) begin
            errors++; $display("[TB] FAIL simul_stat_end: got %h expected %h", rd, 32'(SECOND_ID) << 4);
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL simul_irq_end: got %b expected 0", irq); end
    endtask

    task automatic test_lost();
        bus_write(A_EN, 32'h0);
        for (int i = 0; i < 255; i++) begin
            match = 4'b1000;
            tick();
            match = 4'b0000;
            tick();
        end
        bus_read(A_LOST, rd);
        checks++;
        if (rd !== 32'hFE00_0000) begin errors++; $display("[TB] FAIL lost_count_255: got %h expected fe000000", rd); end
        for (int i = 0; i < 45; i++) begin
            match = 4'b1000;
            tick();
            match = 4'b0000;
            tick();
        end
        bus_read(A_LOST, rd);
        checks++;
        if (rd !== 32'hFF00_0000) begin errors++; $display("[TB] FAIL lost_saturate: got %h expected ff000000", rd); end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("[TB] FAIL lost_pend: got %h expected 00000008", rd); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL lost_irq_disabled: got %b expected 0", irq); end
        bus_write(A_LOST, 32'h0);
        bus_read(A_LOST, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL lost_clear: got %h expected 00000000", rd); end
        bus_write(A_PEND, 32'h8);
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL lost_pend_w1c: got %h expected 00000000", rd); end
    endtask

    task automatic test_misuse();
        bus_write(A_EN, 32'h1);
        match = 4'b0001;
        tick();
        match = 4'b0000;
        bus_write(A_CLAIM, 32'h0);
        bus_read(A_STAT, rd);
        checks++;
        if (rd[9:8] !== 2'd1) begin errors++; $display("[TB] FAIL misuse_claim_idle_state: got %0d expected 1", rd[9:8]); end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("[TB] FAIL misuse_claim_idle_pend: got %h expected 00000001", rd); end
        bus_write(A_CLAIM, 32'h0);
        bus_write(A_EOI, 32'h2);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h200) begin errors++; $display("[TB] FAIL misuse_bad_eoi: got %h expected 00000200", rd); end
        bus_write(A_EOI, 32'h0);
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL misuse_good_eoi: got %h expected 00000000", rd); end
    endtask

    task automatic test_collision();
        match = 4'b0010;
        bus_write(A_PEND, 32'h2);
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("[TB] FAIL coll_w1c_vs_edge: got %h expected 00000002", rd); end
        match = 4'b0000;
        bus_write(A_PEND, 32'h2);
        match = 4'b0001;
        tick();
        match = 4'b0000;
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL coll_offer: got %b expected 1", irq); end
        match = 4'b0001;
        bus_write(A_CLAIM, 32'h0);
        match = 4'b0000;
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("[TB] FAIL coll_claim_vs_edge_pend: got %h expected 00000001", rd); end
        bus_read(A_LOST, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL coll_claim_vs_edge_lost: got %h expected 00000000", rd); end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h200) begin errors++; $display("[TB] FAIL coll_stat_active: got %h expected 00000200", rd); end
    endtask

    task automatic test_reset_mid();
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || irq_id !== 2'd0) begin
            errors++; $display("[TB] FAIL rstmid_outputs: got irq=%b id=%0d expected irq=0 id=0", irq, irq_id);
        end
        bus_read(A_EN, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_en: got %h expected 00000000", rd); end
        bus_read(A_PEND, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_pend: got %h expected 00000000", rd); end
        bus_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_stat: got %h expected 00000000", rd); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_lost();
        test_misuse();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_timer_irqc.md
# ahb_timer_irqc

Interrupt controller and arbiter for the four compare channels of the AHB system timer. It takes the timer's sticky match bits and converts their rising edges into per-channel pending events. It arbitrates among enabled pending channels and drives a single CPU interrupt line with a claim / end-of-interrupt handshake. It is a second slave on the same simple AHB select/address/write bus as the timer, sitting between the timer and the CPU interrupt input.

## Interface
Parameters:
- LOST_W, 8, width of the saturating lost-event counter per channel

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  [4:2]  word register index
- HWRITE  in  1  write strobe, qualified by HSEL
- HWDATA  in  32  write data
- HRDATA  out  32  read data, combinational from HADDR
- match  in  4  timer match bits, level, sticky
- irq  out  1  interrupt request to the CPU, registered
- irq_id  out  2  channel currently offered or in service, registered

## Operation
Registers (HADDR), unused bits read 0:
- 0 EN, rw: [3:0] channel enables.
- 1 PEND: read [3:0]; write-1-to-clear.
- 2 CLAIM:
  - Read: {valid[31], 29'b0, cand[1:0]}, the current arbitration winner.
  - Any write performs a claim.
- 3 EOI: write [1:0] = id to end service. Reads 0.
- 4 STAT: read {state[1:0] at [9:8], active_id[1:0] at [5:4], 4'b0}.
- 5 LOST: read {lost3, lost2, lost1, lost0}, each LOST_W≤8 bits, byte-aligned. Any write clears all four counters.

Edge detect and pending:
- match_q is the registered copy of match. An edge is match & ~match_q.
- An edge sets PEND[i] regardless of EN[i].
- An edge on a channel whose PEND is already 1 increments lost[i], saturating at all-ones.

Arbitration:
- Candidates are PEND & EN; the candidate is in service only if not ACTIVE.
- Fixed priority: the lowest index wins.

FSM states: IDLE=0, OFFER=1, ACTIVE=2.
- IDLE → OFFER when any candidate exists.
- OFFER → IDLE when the candidates vanish (cleared or disabled).
- OFFER → ACTIVE on a CLAIM write:
  - active_id latches the winner.
  - PEND[winner] clears.
- ACTIVE → IDLE on an EOI write with id == active_id. A mismatched EOI is ignored.
- A CLAIM in IDLE or ACTIVE is ignored.
- In ACTIVE, new edges (including on the active channel) set pending normally.

Outputs:
- irq = 1 in OFFER only.
- irq_id follows the winner in OFFER and active_id in ACTIVE; it holds its value in IDLE.

## Timing
- Reset values:
  - irq=0, irq_id=0, state=IDLE.
  - EN=0, PEND=0, lost=0, active_id=0, match_q=0.
  - A match held high across reset exit therefore registers an edge in the first cycle.
- Latency:
  - match rising at edge N is sampled at N; PEND sets at N+1.
  - irq rises at N+2 if the channel is enabled and the FSM is in IDLE.
- Register writes take effect at the next HCLK edge. CLAIM read data reflects the winner combinationally.
- Same-cycle collisions:
  - Edge set vs W1C on the same PEND bit: set wins.
  - Claim-clear vs edge on the same channel: the bit ends at 1, and lost is not incremented.
- EOI and a new candidate in the same cycle: the FSM goes to IDLE, then to OFFER on the next cycle (one dead cycle of irq=0).
- Disabling EN in ACTIVE does not abort service.
- Asynchronous reset mid-service returns everything to reset values immediately.

## Configuration
- IRQC_RR_EN defined: round-robin arbitration.
  - A 2-bit pointer holds last-claimed id + 1 (reset 0).
  - The winner is the first candidate at or after the pointer, with wrap-around.
  - The pointer updates on every successful claim.
- IRQC_RR_EN undefined: fixed priority, with channel 0 highest. The pointer logic is absent.

## Test plan
- Single channel:
  - Setup: EN=0x1, then pulse match[0].
  - Expected: irq=1, irq_id=0 two cycles later; CLAIM read returns 0x80000000.
  - Then write CLAIM, then EOI=0: PEND=0, STAT state=0, irq=0.
- Simultaneous edges, EN=0xF, match 0x0→0x6:
  - Fixed priority: claim order is 1 then 2.
  - IRQC_RR_EN with pointer at 2: claim order is 2 then 1.
- Lost counting: with EN=0, toggle match[3] 300 times → PEND[3]=1 and lost3 reads 0xFF. A LOST write → 0.
- Handshake misuse:
  - Setup: EN=0x1, pulse match[0].
  - A CLAIM in IDLE has no effect.
  - An EOI with id 2 while ACTIVE on id 0 keeps state=2.
  - An EOI with id 0 returns state to 0.
- Collision:
  - W1C of PEND[1] in the same cycle as a match[1] edge → PEND[1]=1.
  - Claim of channel 0 in the same cycle as a match[0] edge → PEND[0]=1, lost0 unchanged.
- Reset mid-service: assert HRESETn=0 while ACTIVE → irq=0, EN=0, PEND=0, and STAT=0 immediately.
